// File: rtl/fsk_frame_pkg.sv
// fsk_frame_pkg
// Shared types and default frame geometry for the FSK receive deframer.
// No ports. Provides:
//   state_t           frame synchroniser state (HUNT, DATA, CHECK)
//   DEF_WORD_W        default payload width (8 data bits + check bit)
//   DEF_SYNC_W        default sync word length
//   DEF_SYNC_PATTERN  default sync word, MSB transmitted first
//   FRAME_W           total bits per frame at the default geometry
//   max_int           helper for sizing counters from two lengths
package fsk_frame_pkg;

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    CHECK
  } state_t;

  localparam int DEF_WORD_W = 9;
  localparam int DEF_SYNC_W = 7;
  localparam logic [6:0] DEF_SYNC_PATTERN = 7'b1110010;
  localparam int FRAME_W = DEF_SYNC_W + DEF_WORD_W;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fsk_deframer_if.sv
// fsk_deframer_if
// Bundles the serial bit input and the parallel word output of the deframer.
// Signals:
//   bit_in      recovered serial bit (valid only with bit_valid)
//   bit_valid   bit strobe
//   dataout     last assembled word, MSB = first received payload bit
//   data_valid  one-cycle pulse when dataout is updated
//   locked      frame lock flag
//   sync_miss   one-cycle pulse when a sync check fails
// Modports:
//   master  bit source / word consumer side (drives bit_in, bit_valid)
//   slave   deframer side (drives the word and status outputs)
interface fsk_deframer_if
  import fsk_frame_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) ();

  logic              bit_in;
  logic              bit_valid;
  logic [WORD_W-1:0] dataout;
  logic              data_valid;
  logic              locked;
  logic              sync_miss;

  modport master (
    output bit_in, bit_valid,
    input  dataout, data_valid, locked, sync_miss
  );

  modport slave (
    input  bit_in, bit_valid,
    output dataout, data_valid, locked, sync_miss
  );

endinterface

// File: rtl/fsk_deframer_sync_correlator.sv
// sync_correlator
// Holds the sync-length shift register of received bits and compares the
// value it is about to take (including the current bit) with the sync word.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset (clears the shift register)
//   shift_en  accept bit_in this cycle
//   bit_in    serial bit
//   match     combinational: post-shift value equals SYNC_PATTERN
module sync_correlator
  import fsk_frame_pkg::*;
#(
  parameter int                SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  logic [SYNC_W-1:0] sreg;
  logic [SYNC_W-1:0] shifted;

  // The compare looks at the value including the bit being accepted now, so
  // the FSM can act on a sync hit in the same edge that accepts its last bit.
  assign shifted = {sreg[SYNC_W-2:0], bit_in};
  assign match   = (shifted == SYNC_PATTERN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
    end else if (shift_en) begin
      sreg <= shifted;
    end
  end

endmodule

// File: rtl/fsk_deframer.sv
// fsk_deframer
// Frame synchroniser for the FSK receive path. Hunts for the sync word,
// acquires lock after LOCK_N consecutive sync hits, flywheels through up to
// UNLOCK_N-1 consecutive sync misses, and emits each payload word received
// while locked as a parallel word with a one-cycle valid pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    fsk_deframer_if.slave: bit_in/bit_valid in;
//          dataout/data_valid/locked/sync_miss out (all registered)
module fsk_deframer
  import fsk_frame_pkg::*;
#(
  parameter int                WORD_W       = DEF_WORD_W,
  parameter int                SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
  parameter int                LOCK_N       = 2,
  parameter int                UNLOCK_N     = 3
) (
  input logic           clk,
  input logic           reset,
  fsk_deframer_if.slave bus
);

  localparam int CNT_W  = $clog2(max_int(WORD_W, SYNC_W));
  localparam int HIT_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W = $clog2(UNLOCK_N + 1);

  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [HIT_W-1:0]  HIT_MAX   = HIT_W'(LOCK_N);
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_N - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_N - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HIT_W-1:0]  hits_q, hits_d;
  logic [MISS_W-1:0] misses_q, misses_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] word_next;
  logic [WORD_W-1:0] dataout_q, dataout_d;
  logic              data_valid_q, data_valid_d;
  logic              locked_q, locked_d;
  logic              sync_miss_q, sync_miss_d;
  logic              match;

  sync_correlator #(
    .SYNC_W       (SYNC_W),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_corr (
    .clk      (clk),
    .reset    (reset),
    .shift_en (bus.bit_valid),
    .bit_in   (bus.bit_in),
    .match    (match)
  );

  assign word_next = {word_q[WORD_W-2:0], bus.bit_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      word_q       <= '0;
      dataout_q    <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_miss_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      word_q       <= word_d;
      dataout_q    <= dataout_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
      sync_miss_q  <= sync_miss_d;
    end
  end

  // Everything holds on cycles without an accepted bit; only the two pulse
  // outputs fall back to 0.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    word_d       = word_q;
    dataout_d    = dataout_q;
    data_valid_d = 1'b0;
    locked_d     = locked_q;
    sync_miss_d  = 1'b0;

    if (bus.bit_valid) begin
      case (state_q)
        HUNT: begin
          if (match) begin
            state_d  = DATA;
            hits_d   = HIT_W'(1);
            misses_d = '0;
            cnt_d    = '0;
          end
        end

        // Words finished while unlocked are dropped without touching dataout.
        DATA: begin
          word_d = word_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == WORD_LAST) begin
            cnt_d   = '0;
            state_d = CHECK;
            if (locked_q) begin
              dataout_d    = word_next;
              data_valid_d = 1'b1;
            end
          end
        end

        // A miss while locked keeps the frame timing (flywheel) until
        // UNLOCK_N misses in a row; a miss while unlocked restarts the hunt.
        CHECK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SYNC_LAST) begin
            cnt_d = '0;
            if (match) begin
              misses_d = '0;
              state_d  = DATA;
              if (hits_q >= HIT_LAST) begin
                hits_d   = HIT_MAX;
                locked_d = 1'b1;
              end else begin
                hits_d = hits_q + 1'b1;
              end
            end else begin
              sync_miss_d = 1'b1;
              if (!locked_q) begin
                state_d = HUNT;
                hits_d  = '0;
              end else if (misses_q >= MISS_LAST) begin
                locked_d = 1'b0;
                hits_d   = '0;
                misses_d = '0;
                state_d  = HUNT;
              end else begin
                misses_d = misses_q + 1'b1;
                state_d  = DATA;
              end
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign bus.dataout    = dataout_q;
  assign bus.data_valid = data_valid_q;
  assign bus.locked     = locked_q;
  assign bus.sync_miss  = sync_miss_q;

endmodule

// File: tb/tb_fsk_deframer.sv
// tb_fsk_deframer
// Directed frame sequences against fsk_deframer. Words that should reach the
// output are queued when their frame is sent; a monitor pops and compares on
// every data_valid pulse, counts sync_miss pulses, and checks that dataout
// holds between pulses.
module tb_fsk_deframer;
  import fsk_frame_pkg::*;

  localparam logic [6:0] SYNC = 7'b1110010;
  localparam logic [6:0] BAD  = 7'b1110011;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  fsk_deframer_if #(.WORD_W(9)) bus ();

  fsk_deframer #(
    .WORD_W       (9),
    .SYNC_W       (7),
    .SYNC_PATTERN (7'b1110010),
    .LOCK_N       (2),
    .UNLOCK_N     (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         checks    = 0;
  int         errors    = 0;
  int         miss_seen = 0;
  int         exp_miss  = 0;
  logic [8:0] exp_q[$];
  logic [8:0] prev_data = '0;
  bit         prev_reset_high = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drives one accepted bit, optionally checking locked on the cycle it is
  // presented, then gap idle cycles with a scrambled bit_in.
  task automatic applyStimulus(input logic b, input int gap,
                               input bit do_lock_check, input logic exp_lock);
    @(negedge clk);
    if (do_lock_check) checkOutput("locked", {31'b0, bus.locked}, {31'b0, exp_lock});
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    repeat (gap) begin
      @(negedge clk);
      bus.bit_valid = 1'b0;
      bus.bit_in    = ~b;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.bit_valid = 1'b0;
    end
  endtask

  // exp_lock is the lock state expected once the frame's sync has been taken.
  task automatic send_frame(input logic [6:0] s, input logic [8:0] w, input int gap,
                            input logic exp_lock, input bit expect_word);
    if (expect_word) exp_q.push_back(w);
    for (int i = 6; i >= 0; i--) applyStimulus(s[i], gap, 1'b0, 1'b0);
    for (int i = 8; i >= 0; i--) applyStimulus(w[i], gap, (i == 8), exp_lock);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.bit_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_locked",  {31'b0, bus.locked}, 32'd0);
    checkOutput("reset_dataout", {23'b0, bus.dataout}, 32'd0);
    checkOutput("reset_dvalid",  {31'b0, bus.data_valid}, 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic check_misses(input string name);
    checkOutput(name, miss_seen, exp_miss);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_data_valid: got dataout %0h expected no pulse", bus.dataout);
        end else begin
          checkOutput("dataout", {23'b0, bus.dataout}, {23'b0, exp_q.pop_front()});
        end
      end else if (prev_reset_high) begin
        checkOutput("dataout_hold", {23'b0, bus.dataout}, {23'b0, prev_data});
      end
      if (bus.sync_miss === 1'b1) miss_seen++;
    end else begin
      checkOutput("reset_dvalid_hold", {31'b0, bus.data_valid}, 32'd0);
    end
    prev_data       = bus.dataout;
    prev_reset_high = (reset === 1'b1);
  end

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [39:0] prefix;
    prefix        = 40'hAA_AAAA_AAAA;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("init_locked",    {31'b0, bus.locked}, 32'd0);
    checkOutput("init_dataout",   {23'b0, bus.dataout}, 32'd0);
    checkOutput("init_sync_miss", {31'b0, bus.sync_miss}, 32'd0);
    #2 reset = 1'b1;

    $display("[TB] clean acquisition");
    send_frame(SYNC, 9'h1A5, 0, 1'b0, 1'b0);
    send_frame(SYNC, 9'h0F3, 0, 1'b1, 1'b1);
    send_frame(SYNC, 9'h155, 0, 1'b1, 1'b1);
    idle_cycles(3);
    check_misses("miss_count_clean");

    $display("[TB] single bad sync while locked");
    send_frame(BAD, 9'h0AA, 0, 1'b1, 1'b1);
    exp_miss++;
    send_frame(SYNC, 9'h033, 0, 1'b1, 1'b1);
    idle_cycles(3);
    check_misses("miss_count_flywheel");

    $display("[TB] three bad syncs and re-acquire");
    send_frame(BAD, 9'h1E1, 0, 1'b1, 1'b1);
    send_frame(BAD, 9'h01F, 0, 1'b1, 1'b1);
    send_frame(BAD, 9'h000, 0, 1'b0, 1'b0);
    exp_miss += 3;
    send_frame(SYNC, 9'h0C6, 0, 1'b0, 1'b0);
    send_frame(SYNC, 9'h139, 0, 1'b1, 1'b1);
    idle_cycles(3);
    check_misses("miss_count_unlock");

    $display("[TB] sparse strobes after no-sync prefix");
    do_reset();
    for (int i = 39; i >= 0; i--) applyStimulus(prefix[i], 3, 1'b0, 1'b0);
    send_frame(SYNC, 9'h0F0, 3, 1'b0, 1'b0);
    send_frame(SYNC, 9'h1C3, 3, 1'b1, 1'b1);
    send_frame(SYNC, 9'h05A, 3, 1'b1, 1'b1);
    idle_cycles(6);
    check_misses("miss_count_sparse");

    $display("[TB] bad sync while unlocked");
    do_reset();
    send_frame(SYNC, 9'h0FF, 0, 1'b0, 1'b0);
    send_frame(BAD,  9'h000, 0, 1'b0, 1'b0);
    exp_miss++;
    send_frame(SYNC, 9'h111, 0, 1'b0, 1'b0);
    send_frame(SYNC, 9'h0A5, 0, 1'b1, 1'b1);
    idle_cycles(3);
    check_misses("miss_count_unlocked");

    $display("[TB] reset mid-payload while locked");
    for (int i = 6; i >= 0; i--) applyStimulus(SYNC[i], 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    do_reset();
    send_frame(SYNC, 9'h1F0, 0, 1'b0, 1'b0);
    send_frame(SYNC, 9'h00F, 0, 1'b1, 1'b1);
    idle_cycles(4);
    check_misses("miss_count_final");

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
